// File: rtl/spi_flash_pkg.sv
// Shared types, opcodes and decode helper for the SPI NOR flash responder.
package spi_flash_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 5;

    localparam logic [BYTE_W-1:0] OP_READ = 8'h03;
    localparam logic [BYTE_W-1:0] OP_FAST = 8'h0B;
    localparam logic [BYTE_W-1:0] OP_ID   = 8'h9F;
    localparam logic [BYTE_W-1:0] OP_WAKE = 8'hAB;
    localparam logic [BYTE_W-1:0] OP_PD   = 8'hB9;

    typedef enum logic [2:0] {
        CMD,
        ADDR,
        DUMMY,
        DATA,
        IDOUT,
        IGNORE
    } state_e;

    // While powered down only the wake opcode is honoured; it still lands in IGNORE.
    function automatic state_e decode_op(input logic [BYTE_W-1:0] op, input logic pd);
        state_e st;
        st = IGNORE;
        if (!pd) begin
            case (op)
                OP_READ, OP_FAST: st = ADDR;
                OP_ID:            st = IDOUT;
                default:          st = IGNORE;
            endcase
        end
        return st;
    endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Two-flop synchroniser for one SPI pin with rise/fall pulses on the synchronised level.
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= pin;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level  = sync_q;
    assign rise_c = sync_q & ~prev_q;
    assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 single-bit NOR flash responder (READ, FAST READ, JEDEC ID, power-down/wake).
// The memory array is preloaded by the surrounding board bench; this block only reads it.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int unsigned       MEM_BYTES = 1048576,
    parameter logic [ADDR_W-1:0] JEDEC_ID  = 24'hEF4016
) (
    input  logic clk,
    input  logic resetb,
    input  logic csb,
    input  logic sck,
    input  logic io0,
    output logic io1_out,
    output logic io1_oe,
    output logic busy
);

    localparam int unsigned       AW        = $clog2(MEM_BYTES);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_BYTES - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(7);
    localparam logic [CNT_W-1:0]  LAST_ADDR = CNT_W'(23);

    logic [BYTE_W-1:0] mem [MEM_BYTES];

    logic csb_s, csb_rise_c, csb_fall_c;
    logic sck_s, sck_rise_c, sck_fall_c;
    logic io0_s, io0_rise_c, io0_fall_c;

    spi_pin_sync #(.RST_VAL(1'b1)) u_csb_sync (
        .clk(clk), .rst_n(resetb), .pin(csb),
        .level(csb_s), .rise_c(csb_rise_c), .fall_c(csb_fall_c)
    );

    spi_pin_sync #(.RST_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst_n(resetb), .pin(sck),
        .level(sck_s), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
    );

    spi_pin_sync #(.RST_VAL(1'b0)) u_io0_sync (
        .clk(clk), .rst_n(resetb), .pin(io0),
        .level(io0_s), .rise_c(io0_rise_c), .fall_c(io0_fall_c)
    );

    logic unused_ok;
    assign unused_ok = ^{csb_fall_c, sck_s, io0_rise_c, io0_fall_c};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BYTE_W-1:0]  rx_q, rx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BYTE_W-1:0]  tx_q, tx_d;
    logic [1:0]         id_idx_q, id_idx_d;
    logic               pd_q, pd_d;
    logic               pend_q, pend_d;
    logic               io1_out_d, io1_oe_d, busy_d;

    logic [BYTE_W-1:0]  rx_next_c;
    logic [ADDR_W-1:0]  addr_shift_c;
    logic [BYTE_W-1:0]  mem_q_byte_c;
    logic [BYTE_W-1:0]  mem_shift_byte_c;
    state_e             dec_c;

    assign rx_next_c        = {rx_q[BYTE_W-2:0], io0_s};
    assign addr_shift_c     = {addr_q[ADDR_W-2:0], io0_s};
    assign mem_q_byte_c     = mem[addr_q[AW-1:0]];
    assign mem_shift_byte_c = mem[addr_shift_c[AW-1:0]];
    assign dec_c            = decode_op(rx_next_c, pd_q);

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a + ADDR_W'(1)) & ADDR_MASK;
    endfunction

    function automatic logic [BYTE_W-1:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return JEDEC_ID[23:16];
            2'd1:    return JEDEC_ID[15:8];
            2'd2:    return JEDEC_ID[7:0];
            default: return 8'hFF;
        endcase
    endfunction

    // Next-state and next-output logic; csb high overrides any sck edge in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        id_idx_d  = id_idx_q;
        pd_d      = pd_q;
        pend_d    = pend_q;
        io1_out_d = io1_out;
        io1_oe_d  = io1_oe;
        busy_d    = busy;

        if (csb_s) begin
            state_d  = CMD;
            cnt_d    = '0;
            io1_oe_d = 1'b0;
            busy_d   = 1'b0;
            if (csb_rise_c && pend_q) begin
                pd_d   = 1'b1;
                pend_d = 1'b0;
            end
        end else if (sck_rise_c) begin
            busy_d = 1'b1;
            case (state_q)
                CMD: begin
                    rx_d  = rx_next_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = dec_c;
                        if (rx_next_c == OP_WAKE) pd_d = 1'b0;
                        if (rx_next_c == OP_PD && !pd_q) pend_d = 1'b1;
                        if (dec_c == IDOUT) begin
                            tx_d     = id_byte(2'd0);
                            id_idx_d = 2'd1;
                        end
                    end
                end
                ADDR: begin
                    addr_d = addr_shift_c;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d = '0;
                        if (rx_q == OP_FAST) begin
                            state_d = DUMMY;
                            addr_d  = addr_shift_c & ADDR_MASK;
                        end else begin
                            state_d = DATA;
                            tx_d    = mem_shift_byte_c;
                            addr_d  = wrap_inc(addr_shift_c);
                        end
                    end
                end
                DUMMY: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = DATA;
                        tx_d    = mem_q_byte_c;
                        addr_d  = wrap_inc(addr_q);
                    end
                end
                default: ;
            endcase
        end else if (sck_fall_c && (state_q == DATA || state_q == IDOUT)) begin
            io1_out_d = tx_q[BYTE_W-1];
            io1_oe_d  = 1'b1;
            if (cnt_q == LAST_BIT) begin
                cnt_d = '0;
                if (state_q == DATA) begin
                    tx_d   = mem_q_byte_c;
                    addr_d = wrap_inc(addr_q);
                end else begin
                    tx_d     = id_byte(id_idx_q);
                    id_idx_d = (id_idx_q == 2'd3) ? 2'd3 : id_idx_q + 2'd1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                tx_d  = {tx_q[BYTE_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q  <= CMD;
            cnt_q    <= '0;
            rx_q     <= '0;
            addr_q   <= '0;
            tx_q     <= '0;
            id_idx_q <= '0;
            pd_q     <= 1'b0;
            pend_q   <= 1'b0;
            io1_out  <= 1'b0;
            io1_oe   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            addr_q   <= addr_d;
            tx_q     <= tx_d;
            id_idx_q <= id_idx_d;
            pd_q     <= pd_d;
            pend_q   <= pend_d;
            io1_out  <= io1_out_d;
            io1_oe   <= io1_oe_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: host tasks queue expected bytes, a monitor checks MISO.
module tb_spi_flash_responder;

    localparam int unsigned MEM_BYTES = 1048576;
    localparam int unsigned HALF_CLKS = 8;

    logic clk = 1'b0;
    logic resetb;
    logic csb;
    logic sck;
    logic io0;
    logic io1_out;
    logic io1_oe;
    logic busy;

    logic       expect_oe = 1'b0;
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    spi_flash_responder #(
        .MEM_BYTES(MEM_BYTES),
        .JEDEC_ID (24'hEF4016)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .csb    (csb),
        .sck    (sck),
        .io0    (io0),
        .io1_out(io1_out),
        .io1_oe (io1_oe),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic half();
        repeat (HALF_CLKS) @(negedge clk);
    endtask

    task automatic bit_x(input logic b, input logic oe_exp);
        io0       = b;
        expect_oe = oe_exp;
        half();
        sck = 1'b1;
        half();
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) bit_x(v[i], 1'b0);
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 23; i >= 0; i--) bit_x(a[i], 1'b0);
    endtask

    task automatic clock_bits(input int n, input logic oe_exp);
        for (int i = 0; i < n; i++) bit_x(1'b0, oe_exp);
    endtask

    task automatic start();
        csb = 1'b0;
        half();
    endtask

    task automatic stop();
        expect_oe = 1'b0;
        csb       = 1'b1;
        half();
        half();
    endtask

    // Monitor: samples MISO on each host sck rise, checks drive enable, assembles bytes.
    initial begin
        int         nbits;
        logic [7:0] shreg;
        logic [7:0] exp_b;
        nbits = 0;
        shreg = '0;
        forever begin
            @(posedge sck or posedge csb);
            if (csb) begin
                nbits = 0;
            end else begin
                check("io1_oe", 32'(io1_oe), 32'(expect_oe));
                if (io1_oe && expect_oe) begin
                    shreg = {shreg[6:0], io1_out};
                    nbits++;
                    if (nbits == 8) begin
                        nbits = 0;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rx_byte: got %02h, expected no byte", shreg);
                        end else begin
                            exp_b = exp_q.pop_front();
                            check("rx_byte", 32'(shreg), 32'(exp_b));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetb = 1'b0;
        csb    = 1'b1;
        sck    = 1'b0;
        io0    = 1'b0;

        dut.mem[0] = 8'h93;
        dut.mem[1] = 8'h00;
        dut.mem[2] = 8'h00;
        dut.mem[3] = 8'h00;
        dut.mem[4] = 8'hA5;
        dut.mem[5] = 8'h3C;
        dut.mem[6] = 8'hC3;
        dut.mem[7] = 8'h7E;
        dut.mem[MEM_BYTES-1] = 8'h5A;

        repeat (4) @(negedge clk);
        check("reset io1_oe", 32'(io1_oe), 32'd0);
        check("reset io1_out", 32'(io1_out), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        resetb = 1'b1;
        half();

        // READ from 0: four bytes
        start();
        send_byte(8'h03);
        check("busy in cmd", 32'(busy), 32'd1);
        send_addr(24'h000000);
        exp_q.push_back(8'h93); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        clock_bits(32, 1'b1);
        stop();
        check("busy after csb", 32'(busy), 32'd0);

        // FAST READ from 1 with 8 dummy clocks
        start();
        send_byte(8'h0B);
        send_addr(24'h000001);
        clock_bits(8, 1'b0);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        clock_bits(16, 1'b1);
        stop();

        // FAST READ from 4, continuing across byte reloads
        start();
        send_byte(8'h0B);
        send_addr(24'h000004);
        clock_bits(8, 1'b0);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3); exp_q.push_back(8'h7E);
        clock_bits(32, 1'b1);
        stop();

        // READ at the top address wraps to 0
        start();
        send_byte(8'h03);
        send_addr(24'(MEM_BYTES - 1));
        exp_q.push_back(8'h5A); exp_q.push_back(8'h93);
        clock_bits(16, 1'b1);
        stop();

        // JEDEC ID then FF fill
        start();
        send_byte(8'h9F);
        exp_q.push_back(8'hEF); exp_q.push_back(8'h40);
        exp_q.push_back(8'h16); exp_q.push_back(8'hFF);
        clock_bits(32, 1'b1);
        stop();

        // Power down: READ is ignored, wake restores it
        start();
        send_byte(8'hB9);
        stop();
        start();
        send_byte(8'h03);
        send_addr(24'h000000);
        clock_bits(8, 1'b0);
        stop();
        start();
        send_byte(8'h9F);
        clock_bits(8, 1'b0);
        stop();
        start();
        send_byte(8'hAB);
        stop();
        start();
        send_byte(8'h03);
        send_addr(24'h000000);
        exp_q.push_back(8'h93);
        clock_bits(8, 1'b1);
        stop();

        // Abort after 13 address bits, then a clean READ from 2
        start();
        send_byte(8'h03);
        for (int i = 0; i < 13; i++) bit_x(1'b1, 1'b0);
        stop();
        start();
        send_byte(8'h03);
        send_addr(24'h000002);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hA5);
        clock_bits(24, 1'b1);
        stop();

        // Reset in the middle of a data phase
        start();
        send_byte(8'h03);
        send_addr(24'h000000);
        exp_q.push_back(8'h93);
        clock_bits(11, 1'b1);
        resetb = 1'b0;
        #1;
        check("io1_oe after reset", 32'(io1_oe), 32'd0);
        check("busy after reset", 32'(busy), 32'd0);
        stop();
        resetb = 1'b1;
        half();
        start();
        send_byte(8'h9F);
        exp_q.push_back(8'hEF);
        clock_bits(8, 1'b1);
        stop();

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
